// File: rtl/sample_tick_generator.sv
// sample_tick_generator: fractional phase-accumulator divider emitting burst or continuous sampling ticks
module sample_tick_generator #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int ACC_WIDTH          = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [WORD_LENGTH-1:0] count_i,
  output logic                   tick_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [WORD_LENGTH-1:0] tick_count_o
);
  localparam logic [ACC_WIDTH-1:0] step_inc = ACC_WIDTH'(SAMPLING_FREQUENCY);
  localparam logic [ACC_WIDTH-1:0] wrap_mod = ACC_WIDTH'(SYSTEM_FREQUENCY);
  if (!(SAMPLING_FREQUENCY > 0 && SAMPLING_FREQUENCY < SYSTEM_FREQUENCY)) begin : g_bad_ratio
    $error("SAMPLING_FREQUENCY must lie strictly between 0 and SYSTEM_FREQUENCY");
  end
  if (((64'(SYSTEM_FREQUENCY) + 64'(SAMPLING_FREQUENCY)) >> ACC_WIDTH) != 64'd0) begin : g_bad_acc
    $error("ACC_WIDTH too narrow for SYSTEM_FREQUENCY + SAMPLING_FREQUENCY");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc, sum;
  logic [WORD_LENGTH-1:0] count_q, next_count;
  logic                   hit, last;
  always_comb begin
    sum        = acc + step_inc;
    hit        = sum >= wrap_mod;
    next_count = tick_count_o + WORD_LENGTH'(1);
    last       = hit && count_q != '0 && next_count == count_q;
  end
  // acc stays below SYSTEM_FREQUENCY, so sum never overflows and the residue carries the fraction
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      acc          <= '0;
      count_q      <= '0;
      tick_o       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      tick_count_o <= '0;
    end else begin
      tick_o <= 1'b0;
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i && !stop_i) begin
          state        <= RUN;
          busy_o       <= 1'b1;
          count_q      <= count_i;
          acc          <= '0;
          tick_count_o <= '0;
        end
      end else if (stop_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        acc <= hit ? sum - wrap_mod : sum;
        if (hit) begin
          tick_o       <= 1'b1;
          tick_count_o <= next_count;
        end
        if (last) begin
          done_o <= 1'b1;
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sample_tick_generator.sv
// tb_sample_tick_generator: scoreboard bench over three parameterisations against a tick-schedule model
module tb_sample_tick_generator;
  localparam int SYSF[3] = '{100000000, 10, 2};
  localparam int SMPF[3] = '{1000000, 3, 1};
  localparam int WL[3]   = '{16, 16, 4};
  typedef struct {int inst; int e; int cnt; bit last;} ev_t;
  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [2:0]  st = '0, sp = '0, tk, bz, dn;
  logic [15:0] ci [3];
  logic [15:0] tc0, tc1;
  logic [3:0]  tc2;
  int          cyc = 0, n_chk = 0, n_fail = 0, j;
  int          seen [3];
  ev_t         q[$];
  ev_t         ev;
  sample_tick_generator u0 (
    .clock_i(clk), .reset_ni(reset_ni), .start_i(st[0]), .stop_i(sp[0]), .count_i(ci[0]),
    .tick_o(tk[0]), .busy_o(bz[0]), .done_o(dn[0]), .tick_count_o(tc0));
  sample_tick_generator #(.WORD_LENGTH(16), .SYSTEM_FREQUENCY(10), .SAMPLING_FREQUENCY(3)) u1 (
    .clock_i(clk), .reset_ni(reset_ni), .start_i(st[1]), .stop_i(sp[1]), .count_i(ci[1]),
    .tick_o(tk[1]), .busy_o(bz[1]), .done_o(dn[1]), .tick_count_o(tc1));
  sample_tick_generator #(.WORD_LENGTH(4), .SYSTEM_FREQUENCY(2), .SAMPLING_FREQUENCY(1)) u2 (
    .clock_i(clk), .reset_ni(reset_ni), .start_i(st[2]), .stop_i(sp[2]), .count_i(ci[2][3:0]),
    .tick_o(tk[2]), .busy_o(bz[2]), .done_o(dn[2]), .tick_count_o(tc2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int tcv(input int i);
    return i == 0 ? int'(tc0) : i == 1 ? int'(tc1) : int'(tc2);
  endfunction
  // k-th tick lands on edge ceil(k * SYS / SAMP) after the start edge
  function automatic int t_edge(input int k, input int i);
    longint num = longint'(k) * SYSF[i];
    return int'((num + SMPF[i] - 1) / SMPF[i]);
  endfunction
  task automatic chk(input int i, input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0d, expected %0d (cycle %0d)", i, nm, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_to(input int e);
    while (cyc < e) step(1);
  endtask
  task automatic plan(input int i, input int c0, input int n, input int cstop, output int cnt);
    cnt = 0;
    for (int k = 1; k <= 100000; k++) begin
      int e;
      if (n != 0 && k > n) break;
      e = c0 + t_edge(k, i);
      if (e >= cstop) break;
      q.push_back('{i, e, k % (1 << WL[i]), n != 0 && k == n});
      cnt = k;
    end
  endtask
  task automatic go(input int i, input int n, input int soff, output int c0, output int ex);
    c0 = cyc + 1;
    plan(i, c0, n, soff != 0 ? c0 + soff : 32'h3fffffff, ex);
    ci[i] = 16'(n);
    st[i] = 1'b1;
    step(1);
    st[i] = 1'b0;
    chk(i, "busy after start", bz[i], 1);
    chk(i, "count cleared on start", tcv(i), 0);
  endtask
  task automatic quiet(input string nm);
    for (int i = 0; i < 3; i++) chk(i, nm, {tk[i], bz[i], dn[i]} != 3'b0 || tcv(i) != 0, 0);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tk[i]) begin
        j = -1;
        for (int m = 0; m < q.size(); m++) if (j < 0 && q[m].inst == i) j = m;
        chk(i, "tick expected", j >= 0, 1);
        if (j >= 0) begin
          ev = q[j];
          q.delete(j);
          chk(i, "tick cycle", cyc, ev.e);
          chk(i, "tick count", tcv(i), ev.cnt);
          chk(i, "done with tick", dn[i], ev.last);
        end
        seen[i]++;
      end else if (dn[i]) chk(i, "done without tick", dn[i], 0);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, ex, s, n, soff;
    for (int i = 0; i < 3; i++) begin
      ci[i] = '0;
      seen[i] = 0;
    end
    step(3);
    quiet("reset state");
    reset_ni = 1'b1;
    repeat (500) begin
      step(1);
      quiet("idle quiet");
    end
    go(0, 3, 0, c0, ex);
    wait_to(c0 + 299);
    chk(0, "busy before last tick", bz[0], 1);
    step(1);
    chk(0, "busy after burst", bz[0], 0);
    chk(0, "burst tick count", tcv(0), 3);
    step(1);
    chk(0, "done cleared", dn[0], 0);
    go(0, 10, 450, c0, ex);
    wait_to(c0 + 449);
    sp[0] = 1'b1;
    step(1);
    sp[0] = 1'b0;
    chk(0, "busy after stop", bz[0], 0);
    chk(0, "count held after stop", tcv(0), ex);
    step(200);
    st[0] = 1'b1;
    sp[0] = 1'b1;
    step(1);
    st[0] = 1'b0;
    sp[0] = 1'b0;
    chk(0, "start+stop stays idle", bz[0], 0);
    chk(0, "count still held", tcv(0), 4);
    go(0, 2, 0, c0, ex);
    wait_to(c0 + 149);
    st[0] = 1'b1;
    ci[0] = 16'd7;
    step(1);
    st[0] = 1'b0;
    chk(0, "start in run ignored", bz[0], 1);
    wait_to(c0 + 200);
    chk(0, "busy after second tick", bz[0], 0);
    chk(0, "ignored-start count", tcv(0), 2);
    step(50);
    chk(0, "stays idle", bz[0], 0);
    s = seen[1];
    go(1, 0, 101, c0, ex);
    wait_to(c0 + 100);
    sp[1] = 1'b1;
    step(1);
    sp[1] = 1'b0;
    chk(1, "ticks in 100 cycles", seen[1] - s, 30);
    chk(1, "continuous count", tcv(1), ex);
    chk(1, "busy after stop", bz[1], 0);
    repeat (10) begin
      n = int'($urandom_range(0, 9));
      soff = (n == 0 || $urandom_range(0, 2) == 0) ? int'($urandom_range(5, 40)) : 0;
      step(int'($urandom_range(1, 4)));
      go(1, n, soff, c0, ex);
      if (soff != 0) begin
        wait_to(c0 + soff - 1);
        sp[1] = 1'b1;
        step(1);
        sp[1] = 1'b0;
      end else wait_to(c0 + t_edge(n, 1));
      chk(1, "random burst busy", bz[1], 0);
      chk(1, "random burst count", tcv(1), ex % 65536);
    end
    go(2, 0, 75, c0, ex);
    wait_to(c0 + 75);
    chk(2, "wrapped count", tcv(2), ex % 16);
    chk(2, "busy in continuous", bz[2], 1);
    #1;
    reset_ni = 1'b0;
    #1;
    quiet("async reset");
    step(2);
    reset_ni = 1'b1;
    step(3);
    quiet("idle after reset");
    chk(-1, "pending expected ticks", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_tick_generator.md
Name: sample_tick_generator

Overview:
- Produces the `tick_i` sampling strobe consumed by the sampling-window timer.
- Divides the system clock down to SAMPLING_FREQUENCY with a fractional phase accumulator, so non-integer ratios average out exactly.
- Supports bursts of N ticks, or continuous ticking when N = 0.
- Handshake: start/stop controls, busy status, end-of-burst done pulse.

Parameters:
- WORD_LENGTH, 16: width of burst length and tick counter.
- SYSTEM_FREQUENCY, 100000000: clock_i frequency in Hz.
- SAMPLING_FREQUENCY, 1000000: output tick rate in Hz. Must satisfy 0 < SAMPLING_FREQUENCY < SYSTEM_FREQUENCY; elaboration error otherwise.
- ACC_WIDTH, 32: phase accumulator width. Must hold SYSTEM_FREQUENCY + SAMPLING_FREQUENCY without overflow; elaboration error otherwise.

Ports:
- clock_i, input, 1: system clock, rising edge.
- reset_ni, input, 1: asynchronous, active-low reset.
- start_i, input, 1: level-sampled; begins a burst when the block is idle.
- stop_i, input, 1: aborts the current burst.
- count_i, input, WORD_LENGTH: burst length in ticks, latched on start; 0 = continuous.
- tick_o, input-to-timer strobe (output), 1: one-cycle strobe at the sampling rate; drives the timer's tick_i.
- busy_o, output, 1: high while in RUN.
- done_o, output, 1: one-cycle pulse when a finite burst completes.
- tick_count_o, output, WORD_LENGTH: ticks emitted since the last start.

Behaviour:
- Reset (reset_ni low, asynchronous): state = IDLE; acc = 0; latched count = 0; tick_o, busy_o, done_o = 0; tick_count_o = 0. Holds until the first clock edge after deassertion. Reset mid-burst aborts immediately with no done_o.
- States: IDLE, RUN. All outputs are registered.
- IDLE, at edge with stop_i = 1: stay IDLE. stop_i wins over a simultaneous start_i.
- IDLE, at edge with start_i = 1 and stop_i = 0:
  - latch count_i, clear acc and tick_count_o;
  - go to RUN; busy_o = 1 from the next cycle.
  - This edge is E0.
- RUN, each edge with stop_i = 0:
  - sum = acc + SAMPLING_FREQUENCY.
  - If sum >= SYSTEM_FREQUENCY: acc <= sum - SYSTEM_FREQUENCY; tick_o <= 1; tick_count_o <= tick_count_o + 1.
  - Otherwise: acc <= sum; tick_o <= 0.
- Tick timing with defaults: first tick_o is high in the cycle after edge E100. Thereafter ticks occur every 100 cycles, exactly one cycle wide.
- Burst termination (latched count != 0): on the edge producing tick number count:
  - tick_o <= 1, done_o <= 1 (same cycle);
  - state <= IDLE, busy_o <= 0.
  - done_o clears on the following edge.
- Continuous mode (latched count = 0): runs until stop_i; never asserts done_o. tick_count_o wraps from 2^WORD_LENGTH-1 to 0 with no other effect.
- stop_i in RUN (checked first at each edge): state <= IDLE, busy_o <= 0, tick_o <= 0, no done_o. tick_count_o holds its value. acc is cleared on the next start.
- start_i while in RUN: ignored; count_i is not re-latched.
- start_i held high through burst completion: a new burst starts at the edge after returning to IDLE. This guarantees at least one IDLE cycle between bursts.
- Averaging: over any SYSTEM_FREQUENCY cycles in RUN, exactly SAMPLING_FREQUENCY ticks are emitted, ±1.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: hold reset_ni low, then release; run 500 cycles with start_i = 0 -> all outputs 0 throughout.
- Single burst with defaults: count_i = 3, pulse start_i -> tick_o high exactly at cycles 100, 200 and 300 after E0; done_o coincides with the third tick; busy_o drops at cycle 301; tick_count_o = 3.
- Fractional ratio: SYSTEM_FREQUENCY = 10, SAMPLING_FREQUENCY = 3, continuous mode -> tick intervals repeat the pattern 4,3,3 cycles; 30 ticks in 100 cycles.
- Stop mid-burst: count_i = 10, assert stop_i at cycle 450 -> tick_o never rises again, done_o never pulses, busy_o = 0 next cycle, tick_count_o = 4.
- Simultaneous and ignored controls:
  - start_i and stop_i high together in IDLE -> stays IDLE.
  - start_i pulsed at cycle 150 of a count = 2 burst -> no effect; burst ends at the second tick.
- Wrap and reset: continuous mode with WORD_LENGTH = 4, SYSTEM_FREQUENCY = 2, SAMPLING_FREQUENCY = 1 -> tick_count_o goes 15 then 0 and ticking continues. Assert reset_ni low asynchronously mid-cycle -> all outputs 0 before the next edge.
